// File: rtl/mul_issue_unit.sv
// mul_issue_unit: RV32M MUL/MULH/MULHSU/MULHU wrapper around an external
// combinational 32x32 unsigned multiplier (operand stage S1, result stage S2).
module mul_issue_unit #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [63:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag
);

    logic             r_s1_v;
    logic             r_s2_v;
    logic             r_neg;
    logic             r_hi;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [TAG_W-1:0] r_tag1;
    logic [31:0]      r_data;
    logic [TAG_W-1:0] r_tag2;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_acc;
    logic             w_sa;
    logic             w_sb;
    logic             w_na;
    logic             w_nb;
    logic [63:0]      w_p;

    assign w_s2_adv = !r_s2_v | out_ready;
    assign w_s1_adv = r_s1_v & w_s2_adv;
    assign in_ready = !r_s1_v | w_s2_adv;
    assign w_acc    = in_valid & in_ready;

    assign w_sa = (in_op == 2'b01) | (in_op == 2'b10);
    assign w_sb = (in_op == 2'b01);
    assign w_na = w_sa & in_rs1[31];
    assign w_nb = w_sb & in_rs2[31];

    // Sign fix-up on the full 64-bit product before word select.
    assign w_p = r_neg ? (~mul_p + 64'd1) : mul_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v <= 1'b0;
            r_neg  <= 1'b0;
            r_hi   <= 1'b0;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_tag1 <= '0;
        end else begin
            r_s1_v <= !flush & (w_acc | (r_s1_v & !w_s1_adv));
            if (w_acc & !flush) begin
                r_a    <= w_na ? (~in_rs1 + 32'd1) : in_rs1;
                r_b    <= w_nb ? (~in_rs2 + 32'd1) : in_rs2;
                r_neg  <= w_na ^ w_nb;
                r_hi   <= (in_op != 2'b00);
                r_tag1 <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v <= 1'b0;
            r_data <= 32'd0;
            r_tag2 <= '0;
        end else begin
            r_s2_v <= !flush & (w_s1_adv | (r_s2_v & !out_ready));
            if (w_s1_adv & !flush) begin
                r_data <= r_hi ? w_p[63:32] : w_p[31:0];
                r_tag2 <= r_tag1;
            end
        end
    end

    assign mul_a     = r_a;
    assign mul_b     = r_b;
    assign out_valid = r_s2_v;
    assign out_data  = r_data;
    assign out_tag   = r_tag2;

endmodule

// File: tb/tb_mul_issue_unit.sv
// tb_mul_issue_unit: randomized and directed checks of mul_issue_unit
// against a signed-arithmetic reference and an in-order scoreboard.
module tb_mul_issue_unit;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = 2'b00;
    logic [31:0]      in_rs1 = 32'd0;
    logic [31:0]      in_rs2 = 32'd0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic [63:0]      mul_p;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    int errs = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0]      d;
        logic [TAG_W-1:0] t;
    } res_t;
    res_t sb[$];

    mul_issue_unit #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    assign mul_p = {32'd0, mul_a} * {32'd0, mul_b};

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_res(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [127:0] x, y, p;
        x = (op == 2'b01 || op == 2'b10) ? {{96{a[31]}}, a} : {96'd0, a};
        y = (op == 2'b01) ? {{96{b[31]}}, b} : {96'd0, b};
        p = x * y;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1",
                     out_valid, in_ready);
        end
        checks++;
        if (out_data !== 32'd0 || out_tag !== '0
            || mul_a !== 32'd0 || mul_b !== 32'd0) begin
            errs++;
            $display("FAIL reset_data: d=%h t=%h a=%h b=%h want 0",
                     out_data, out_tag, mul_a, mul_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_op(input string nm, input logic [1:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] ea, input logic [31:0] eb,
                                  input logic [31:0] exp);
        logic [TAG_W-1:0] tg;
        tg = TAG_W'($urandom);
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tg;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (mul_a !== ea || mul_b !== eb || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL %s_s1: a=%h b=%h ov=%b want a=%h b=%h ov=0",
                     nm, mul_a, mul_b, out_valid, ea, eb);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp || out_tag !== tg) begin
            errs++;
            $display("FAIL %s: ov=%b d=%h t=%h want ov=1 d=%h t=%h",
                     nm, out_valid, out_data, out_tag, exp, tg);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL %s_drain: out_valid=%b want 0", nm, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops[4];
        logic [31:0] as[4], bs[4];
        int idx, got, stl;
        bit acc, fire, saw_low, prev_st;
        logic [31:0] pd;
        logic [TAG_W-1:0] pt;
        res_t e;
        idx = 0; got = 0; stl = 0; saw_low = 0; prev_st = 0;
        pd = '0; pt = '0;
        for (int i = 0; i < 4; i++) begin
            ops[i] = 2'($urandom); as[i] = pick_val(); bs[i] = pick_val();
        end
        for (int c = 0; c < 40 && got < 4; c++) begin
            out_ready = (stl == 0);
            in_valid = (idx < 4);
            if (idx < 4) begin
                in_op = ops[idx]; in_rs1 = as[idx]; in_rs2 = bs[idx];
                in_tag = TAG_W'(idx + 1);
            end
            #3;
            acc = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (in_valid && !in_ready) saw_low = 1;
            if (out_valid && prev_st) begin
                checks++;
                if (out_data !== pd || out_tag !== pt) begin
                    errs++;
                    $display("FAIL b2b_hold: d=%h t=%h want d=%h t=%h",
                             out_data, out_tag, pd, pt);
                end
            end
            prev_st = out_valid && !out_ready;
            pd = out_data; pt = out_tag;
            if (acc) sb.push_back('{ref_res(in_op, in_rs1, in_rs2), in_tag});
            if (fire) begin
                e = sb.pop_front();
                got++;
                checks++;
                if (out_data !== e.d || out_tag !== e.t) begin
                    errs++;
                    $display("FAIL b2b_res: d=%h t=%h want d=%h t=%h",
                             out_data, out_tag, e.d, e.t);
                end
            end
            @(posedge clk); #1;
            if (acc) idx++;
            if (!out_ready && stl > 0) stl--;
            if (fire && got == 1) stl = 3;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got !== 4 || sb.size() != 0) begin
            errs++;
            $display("FAIL b2b_count: got=%0d left=%0d want 4/0", got, sb.size());
        end
        checks++;
        if (!saw_low) begin
            errs++;
            $display("FAIL b2b_inready: in_ready never low, want low when full");
        end
    endtask

    task automatic test_random();
        bit acc, fire;
        res_t e;
        sb.delete();
        for (int c = 0; c < 320; c++) begin
            bit run;
            run = (c < 300);
            in_valid = run && ($urandom_range(0, 3) != 0);
            out_ready = !run || ($urandom_range(0, 3) != 0);
            in_op = 2'($urandom); in_rs1 = pick_val(); in_rs2 = pick_val();
            in_tag = TAG_W'($urandom);
            #3;
            acc = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (acc) sb.push_back('{ref_res(in_op, in_rs1, in_rs2), in_tag});
            if (fire) begin
                checks++;
                if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL rnd_extra: unexpected result d=%h t=%h",
                             out_data, out_tag);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.d || out_tag !== e.t) begin
                        errs++;
                        $display("FAIL rnd_res: d=%h t=%h want d=%h t=%h",
                                 out_data, out_tag, e.d, e.t);
                    end
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL rnd_drain: left=%0d ov=%b want 0/0", sb.size(), out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'b11; in_rs1 = 32'd3; in_rs2 = 32'd5; in_tag = 5'd7;
        @(posedge clk); #1;
        in_rs1 = 32'd9; in_tag = 5'd8;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errs++;
            $display("FAIL flush_full: in_ready=%b ov=%b want 0/1", in_ready, out_valid);
        end
        out_ready = 1'b1; flush = 1'b1; in_tag = 5'd9;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL flush_ov: out_valid=%b want 0", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL flush_noacc: ov=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        test_single_op("post_flush", 2'b00, 32'd6, 32'd7, 32'd6, 32'd7, 32'd42);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'b01; in_rs1 = 32'h1234_5678;
        in_rs2 = 32'h0000_0010; in_tag = 5'd3;
        @(posedge clk); #1;
        in_tag = 5'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL areset_hs: ov=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        checks++;
        if (out_data !== 32'd0 || mul_a !== 32'd0 || out_tag !== '0) begin
            errs++;
            $display("FAIL areset_data: d=%h a=%h t=%h want 0", out_data, mul_a, out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errs++;
                $display("FAIL areset_stale: out_valid=%b want 0 (cycle %0d)", out_valid, c);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_op("mulhu_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                       32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        test_single_op("mul_8m", 2'b00, 32'h8000_0000, 32'h8000_0000,
                       32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        test_single_op("mulh_8m", 2'b01, 32'h8000_0000, 32'h8000_0000,
                       32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        test_single_op("mulh_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                       32'h0000_0001, 32'h0000_0001, 32'h0000_0000);
        test_single_op("mulhsu_ff", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                       32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        test_single_op("mul_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007,
                       32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB);
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
